fp_add_seq: RTL and testbench

//  Multi-cycle IEEE-style floating-point adder/subtractor, directly downstream of init_number.

---
 rtl/fp_add_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder/subtractor: serial align, add, serial normalize, RNE round.
// Operands are unpacked by two init_number instances; one operation in flight at a time.
`ifndef EXP_SIZE
  `define EXP_SIZE 8
`endif
`ifndef MANTIS_SIZE
  `define MANTIS_SIZE 23
`endif

package fp_add_seq_pkg;
  typedef enum logic [2:0] {T_ZERO, T_NORMAL, T_DENORM, T_INF, T_NAN} num_type_e;
endpackage

module init_number
  import fp_add_seq_pkg::*;
#(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE,
  parameter int N           = 1 + EXP_SIZE + MANTIS_SIZE,
  parameter int W           = MANTIS_SIZE + 4
) (
  input  logic [N-1:0]        op,
  output logic                sign,
  output logic [EXP_SIZE-1:0] exp,
  output num_type_e           typ,
  output logic [W-1:0]        ext_mantis
);
  logic [EXP_SIZE-1:0]    exp_raw;
  logic [MANTIS_SIZE-1:0] frac;

  assign sign    = op[N-1];
  assign exp_raw = op[N-2:MANTIS_SIZE];
  assign frac    = op[MANTIS_SIZE-1:0];

  always_comb begin
    typ = T_NORMAL;
    if (exp_raw == '0)      typ = (frac == '0) ? T_ZERO : T_DENORM;
    else if (&exp_raw)      typ = (frac == '0) ? T_INF  : T_NAN;
  end

  // Denormals share the exponent of the smallest normal so alignment stays uniform.
  assign exp        = (exp_raw == '0) ? EXP_SIZE'(1) : exp_raw;
  assign ext_mantis = {1'b0, (typ == T_NORMAL), frac, 2'b00};
endmodule

module fp_add_seq
  import fp_add_seq_pkg::*;
#(
  parameter int EXP_SIZE    = `EXP_SIZE,
  parameter int MANTIS_SIZE = `MANTIS_SIZE,
  parameter int N           = 1 + EXP_SIZE + MANTIS_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [2:0]   flags,
  output logic         busy
);
  localparam int W  = MANTIS_SIZE + 4;
  localparam int E1 = EXP_SIZE + 1;
  localparam logic [E1-1:0] D_CAP    = E1'(MANTIS_SIZE + 3);
  localparam logic [E1-1:0] EXP_ONES = E1'({EXP_SIZE{1'b1}});
  localparam logic [N-1:0]  QNAN     = {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(MANTIS_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        l_mant_q, l_mant_d, s_mant_q, s_mant_d;
  logic [E1-1:0]       exp_q, exp_d, cnt_q, cnt_d;
  logic                sign_q, sign_d, eff_sub_q, eff_sub_d;
  logic [N-1:0]        result_q, result_d;
  logic [2:0]          flags_q, flags_d;

  logic                sa, sb, sb_raw;
  logic [EXP_SIZE-1:0] ea, eb;
  num_type_e           ta, tb;
  logic [W-1:0]        ma, mb;

  init_number #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_num_a (
    .op(op_a), .sign(sa), .exp(ea), .typ(ta), .ext_mantis(ma)
  );
  init_number #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_num_b (
    .op(op_b), .sign(sb_raw), .exp(eb), .typ(tb), .ext_mantis(mb)
  );

  assign sb = sb_raw ^ sub;

  logic                a_big, g, s, inc, rnd_c;
  logic [E1-1:0]       d_raw, exp_r;
  logic [W-1:0]        sum;
  logic [W-3:0]        rnd;
  logic [MANTIS_SIZE-1:0] frac_r;
  logic                hid_r;

  always_comb begin
    state_d   = state_q;
    l_mant_d  = l_mant_q;
    s_mant_d  = s_mant_q;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    result_d  = result_q;
    flags_d   = flags_q;

    a_big  = (ea > eb) || ((ea == eb) && (ma >= mb));
    d_raw  = a_big ? (E1'(ea) - E1'(eb)) : (E1'(eb) - E1'(ea));
    sum    = eff_sub_q ? (l_mant_q - s_mant_q) : (l_mant_q + s_mant_q);
    g      = l_mant_q[1];
    s      = l_mant_q[0];
    inc    = g & (s | l_mant_q[2]);
    rnd    = {1'b0, l_mant_q[W-2:2]} + {{(W-3){1'b0}}, inc};
    rnd_c  = rnd[MANTIS_SIZE+1];
    exp_r  = exp_q + {{EXP_SIZE{1'b0}}, rnd_c};
    frac_r = rnd_c ? rnd[MANTIS_SIZE:1] : rnd[MANTIS_SIZE-1:0];
    hid_r  = rnd_c | rnd[MANTIS_SIZE];

    unique case (state_q)
      S_IDLE: if (in_valid) begin
        flags_d = 3'b000;
        state_d = S_DONE;
        if (ta == T_NAN || tb == T_NAN || (ta == T_INF && tb == T_INF && sa != sb)) begin
          result_d = QNAN;
          flags_d  = 3'b100;
        end
        else if (ta == T_INF)                    result_d = {sa, op_a[N-2:0]};
        else if (tb == T_INF)                    result_d = {sb, op_b[N-2:0]};
        else if (ta == T_ZERO && tb == T_ZERO)   result_d = {sa & sb, {(N-1){1'b0}}};
        else if (ta == T_ZERO)                   result_d = {sb, op_b[N-2:0]};
        else if (tb == T_ZERO)                   result_d = {sa, op_a[N-2:0]};
        else begin
          l_mant_d  = a_big ? ma : mb;
          s_mant_d  = a_big ? mb : ma;
          exp_d     = a_big ? E1'(ea) : E1'(eb);
          sign_d    = a_big ? sa : sb;
          eff_sub_d = sa ^ sb;
          cnt_d     = (d_raw > D_CAP) ? D_CAP : d_raw;
          state_d   = (d_raw == '0) ? S_ADD : S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Bits leaving the guard position accumulate in sticky.
        s_mant_d = {1'b0, s_mant_q[W-1:2], |s_mant_q[1:0]};
        cnt_d    = cnt_q - E1'(1);
        if (cnt_q == E1'(1)) state_d = S_ADD;
      end
      S_ADD: begin
        if (sum == '0) begin
          result_d = '0;
          flags_d  = 3'b000;
          state_d  = S_DONE;
        end else begin
          l_mant_d = sum;
          state_d  = S_NORM;
        end
      end
      S_NORM: begin
        if (l_mant_q[W-1]) begin
          l_mant_d = {1'b0, l_mant_q[W-1:2], |l_mant_q[1:0]};
          exp_d    = exp_q + E1'(1);
          state_d  = S_ROUND;
        end else if (!l_mant_q[W-2] && exp_q > E1'(1)) begin
          l_mant_d = {l_mant_q[W-2:0], 1'b0};
          exp_d    = exp_q - E1'(1);
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        if (exp_r >= EXP_ONES) begin
          result_d = {sign_q, {EXP_SIZE{1'b1}}, {MANTIS_SIZE{1'b0}}};
          flags_d  = 3'b011;
        end else begin
          // No hidden bit after rounding means the result stayed subnormal.
          result_d = {sign_q, hid_r ? exp_r[EXP_SIZE-1:0] : {EXP_SIZE{1'b0}}, frac_r};
          flags_d  = {2'b00, g | s};
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      l_mant_q  <= '0;
      s_mant_q  <= '0;
      exp_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      l_mant_q  <= l_mant_d;
      s_mant_q  <= s_mant_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed scoreboard bench for fp_add_seq (binary32): results, flags, latency deltas,
// back-pressure hold and mid-operation reset.
module tb_fp_add_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, busy;
  logic [31:0] op_a, op_b, result;
  logic [2:0]  flags;

  fp_add_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Drives one op, waits (bounded) for out_valid, pops the scoreboard and compares.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic [2:0] ef, input string tag,
                        input int hold, output int lat);
    exp_t e, got;
    logic [31:0] held;
    e.res = er; e.flg = ef; e.tag = tag;
    sb_q.push_back(e);
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    got = sb_q.pop_front();
    chk({got.tag, " result"}, result, got.res);
    chk({got.tag, " flags"}, {29'd0, flags}, {29'd0, got.flg});
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold result"}, result, held);
      chk({tag, " hold valid"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " after handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  int lat11, lat12, lat_zero, lat_nan, lat_tmp;
  int seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk("reset ctl", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    chk("reset result", result, 32'h0);
    chk("reset flags", {29'd0, flags}, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, "1+1", 0, lat11);
    run_op(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000, "1+2", 0, lat12);
    chk("align one cycle", lat12, lat11 + 1);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, "1-1", 0, lat_zero);
    chk("zero skips norm/round", lat_zero, lat11 - 2);
    run_op(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, "inf-inf", 0, lat_nan);
    chk("special latency", lat_nan, 1);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, "ovf", 0, lat_tmp);
    run_op(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 3'b001, "tiny", 5, lat_tmp);
    run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, "tie even", 0, lat_tmp);
    run_op(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, "tie odd", 0, lat_tmp);
    run_op(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, "1-2", 0, lat_tmp);
    run_op(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 3'b000, "den+den", 0, lat_tmp);
    run_op(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 3'b000, "min-den", 0, lat_tmp);
    run_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, "nan in", 0, lat_tmp);
    run_op(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000, "x+-inf", 0, lat_tmp);
    run_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, "-0+-0", 0, lat_tmp);
    run_op(32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 3'b000, "+0-+0", 0, lat_tmp);
    run_op(32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 3'b000, "0-2", 0, lat_tmp);

    // Reset while aligning a long shift: op is dropped, outputs return to reset values.
    @(negedge clk);
    op_a = 32'h3F800000; op_b = 32'h30800000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy in align", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst ctl", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
    chk("async rst result", result, 32'h0);
    chk("async rst flags", {29'd0, flags}, 32'h0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("dropped op silent", seen, 0);
    run_op(32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 3'b000, "post rst", 0, lat_tmp);

    chk("scoreboard empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
